// File: rtl/alu_cmd_sequencer.sv
// Front end for ALU_sync: buffers tagged commands, issues them against result-buffer credits,
// tracks ALU latency and returns results with flags and tag in issue order.
module alu_cmd_sequencer #(
    parameter int unsigned CMD_DEPTH = 4,
    parameter int unsigned RES_DEPTH = 2,
    parameter int unsigned TAG_W     = 4,
    parameter int unsigned ALU_LAT   = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [15:0]                 cmd_a,
    input  logic [15:0]                 cmd_b,
    input  logic [3:0]                  cmd_fun,
    input  logic [TAG_W-1:0]            cmd_tag,
    output logic [15:0]                 alu_a,
    output logic [15:0]                 alu_b,
    output logic [3:0]                  alu_fun,
    input  logic [15:0]                 alu_out,
    input  logic [4:0]                  alu_flags,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic [15:0]                 res_data,
    output logic [4:0]                  res_flags,
    output logic [TAG_W-1:0]            res_tag,
    output logic                        res_div0,
    output logic [$clog2(CMD_DEPTH):0]  cmd_count
);
    localparam int unsigned CP_W   = $clog2(CMD_DEPTH);
    localparam int unsigned CC_W   = CP_W + 1;
    localparam int unsigned RP_W   = $clog2(RES_DEPTH);
    localparam int unsigned RC_W   = RP_W + 1;
    localparam int unsigned PIPE_N = ALU_LAT + 1;
    localparam int unsigned IF_W   = $clog2(PIPE_N + 1);
    localparam logic [3:0]  FUN_NOP  = 4'b1111;
    localparam logic [3:0]  FUN_DIV  = 4'b0011;
    localparam logic [4:0]  DIV0_FLG = 5'b01000;

    // Command FIFO storage and pointers (extra MSB distinguishes full from empty)
    logic [15:0]      ca_mem [CMD_DEPTH];
    logic [15:0]      cb_mem [CMD_DEPTH];
    logic [3:0]       cf_mem [CMD_DEPTH];
    logic [TAG_W-1:0] ct_mem [CMD_DEPTH];
    logic [CC_W-1:0]  cwr_ptr;
    logic [CC_W-1:0]  crd_ptr;

    // Result buffer storage and pointers
    logic [15:0]        rd_mem [RES_DEPTH];
    logic [4:0]         rf_mem [RES_DEPTH];
    logic [TAG_W-1:0]   rt_mem [RES_DEPTH];
    logic [RES_DEPTH-1:0] rz_mem;
    logic [RC_W-1:0]    rwr_ptr;
    logic [RC_W-1:0]    rrd_ptr;

    // In-flight pipe: one stage per edge between issue and capture
    logic [PIPE_N-1:0]  pipe_v;
    logic [PIPE_N-1:0]  pipe_z;
    logic [TAG_W-1:0]   pipe_tag [PIPE_N];

    logic [CC_W-1:0]    ccount;
    logic [RC_W-1:0]    rcount;
    logic [IF_W-1:0]    inflight;
    logic [CP_W-1:0]    chead;
    logic [CP_W-1:0]    cwr_idx;
    logic [RP_W-1:0]    rwr_idx;
    logic [RP_W-1:0]    rrd_idx;
    logic               cfull;
    logic               cempty;
    logic               rfull;
    logic               push;
    logic               issue;
    logic               cap;
    logic               pop;
    logic               head_div0;

    always_comb begin
        ccount    = CC_W'(cwr_ptr - crd_ptr);
        rcount    = RC_W'(rwr_ptr - rrd_ptr);
        chead     = crd_ptr[CP_W-1:0];
        cwr_idx   = cwr_ptr[CP_W-1:0];
        rwr_idx   = rwr_ptr[RP_W-1:0];
        rrd_idx   = rrd_ptr[RP_W-1:0];
        cfull     = (ccount == CC_W'(CMD_DEPTH));
        cempty    = (ccount == '0);
        rfull     = (rcount == RC_W'(RES_DEPTH));
        inflight  = '0;
        for (int i = 0; i < int'(PIPE_N); i++) begin
            inflight = inflight + IF_W'(pipe_v[i]);
        end
        cmd_ready = !cfull && !rst;
        push      = cmd_valid && cmd_ready;
        // Credits cover both buffered results and everything still in the ALU pipe
        issue     = !cempty && ((32'(rcount) + 32'(inflight)) < RES_DEPTH);
        head_div0 = (cf_mem[chead] == FUN_DIV) && (cb_mem[chead] == 16'h0000);
        cap       = pipe_v[PIPE_N-1];
        res_valid = (rcount != '0);
        pop       = res_valid && res_ready;
        res_data  = rd_mem[rrd_idx];
        res_flags = rf_mem[rrd_idx];
        res_tag   = rt_mem[rrd_idx];
        res_div0  = rz_mem[rrd_idx];
        cmd_count = ccount;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cwr_ptr <= '0;
            crd_ptr <= '0;
            rwr_ptr <= '0;
            rrd_ptr <= '0;
            pipe_v  <= '0;
            pipe_z  <= '0;
            alu_a   <= '0;
            alu_b   <= '0;
            alu_fun <= FUN_NOP;
            rz_mem  <= '0;
            for (int i = 0; i < int'(PIPE_N); i++) begin
                pipe_tag[i] <= '0;
            end
            for (int i = 0; i < int'(RES_DEPTH); i++) begin
                rd_mem[i] <= '0;
                rf_mem[i] <= '0;
                rt_mem[i] <= '0;
            end
        end else begin
            if (push) begin
                ca_mem[cwr_idx] <= cmd_a;
                cb_mem[cwr_idx] <= cmd_b;
                cf_mem[cwr_idx] <= cmd_fun;
                ct_mem[cwr_idx] <= cmd_tag;
                cwr_ptr         <= cwr_ptr + CC_W'(1);
            end

            if (issue) begin
                alu_a   <= ca_mem[chead];
                alu_b   <= cb_mem[chead];
                alu_fun <= cf_mem[chead];
                crd_ptr <= crd_ptr + CC_W'(1);
            end else begin
                alu_fun <= FUN_NOP;
            end

            pipe_v      <= {pipe_v[PIPE_N-2:0], issue};
            pipe_z      <= {pipe_z[PIPE_N-2:0], issue && head_div0};
            pipe_tag[0] <= ct_mem[chead];
            for (int i = 1; i < int'(PIPE_N); i++) begin
                pipe_tag[i] <= pipe_tag[i-1];
            end

            // Capture ALU output into the result buffer, overriding divide-by-zero results
            if (cap) begin
                rd_mem[rwr_idx] <= pipe_z[PIPE_N-1] ? 16'hFFFF : alu_out;
                rf_mem[rwr_idx] <= pipe_z[PIPE_N-1] ? DIV0_FLG : alu_flags;
                rt_mem[rwr_idx] <= pipe_tag[PIPE_N-1];
                rz_mem[rwr_idx] <= pipe_z[PIPE_N-1];
                rwr_ptr         <= rwr_ptr + RC_W'(1);
            end

            if (pop) begin
                rrd_ptr <= rrd_ptr + RC_W'(1);
            end
        end
    end

    // The credit rule must keep the result buffer from ever being written while full
    res_no_overflow: assert property (@(posedge clk) disable iff (rst) !(cap && rfull && !pop));

endmodule
